// File: rtl/pmem_line_responder.sv
// Line-granular memory responder for the cache pmem protocol with fixed response latency.
// Optional protocol checking is enabled by defining PMEM_PROTOCOL_CHECK_EN.
module pmem_line_responder #(
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned LATENCY   = 10,
  parameter string       INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         error
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  localparam int unsigned NLINES   = 1 << IDX_W;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             is_write_q, is_write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [255:0]     wdata_q, wdata_d;
  logic [255:0]     rdata_q, rdata_d;
  logic             error_q, error_d;

  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [255:0]     mem_wdata;
  logic [255:0]     mem [NLINES];

  logic             req_one, req_both, accept, abort;
  logic [IDX_W-1:0] idx_in;

  assign req_one  = pmem_read ^ pmem_write;
  assign req_both = pmem_read & pmem_write;
  assign idx_in   = pmem_address[IDX_W+4:5];

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [31:0] addr_q, addr_d;
  logic        addr_hi_bad;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^pmem_address[4:0];
  assign addr_hi_bad      = |pmem_address[31:IDX_W+5];
  // Once error is set, nothing more is accepted until reset.
  assign accept           = req_one && !error_q && !addr_hi_bad;
  assign abort            = !req_one || (pmem_write != is_write_q) ||
                            (pmem_address != addr_q) ||
                            (is_write_q && (pmem_wdata != wdata_q));
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{pmem_address[31:IDX_W+5], pmem_address[4:0]};
  assign accept           = req_one;
  assign abort            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    mem_we     = 1'b0;
    mem_idx    = idx_q;
    mem_wdata  = wdata_q;
`ifdef PMEM_PROTOCOL_CHECK_EN
    addr_d     = addr_q;
    if ((state_q == IDLE) && req_one && !error_q && addr_hi_bad) error_d = 1'b1;
    if (((state_q == IDLE) || (state_q == WAIT)) && req_both)    error_d = 1'b1;
    if ((state_q == WAIT) && abort)                              error_d = 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          is_write_d = pmem_write;
          idx_d      = idx_in;
          wdata_d    = pmem_wdata;
          cnt_d      = CNT_INIT;
`ifdef PMEM_PROTOCOL_CHECK_EN
          addr_d     = pmem_address;
`endif
          if (LATENCY == 1) begin
            // Single-cycle latency: commit/fetch straight from the live request.
            state_d   = RESP;
            mem_we    = pmem_write;
            mem_idx   = idx_in;
            mem_wdata = pmem_wdata;
            if (!pmem_write) rdata_d = mem[idx_in];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 8'd1) begin
          state_d = RESP;
          cnt_d   = '0;
          mem_we  = is_write_q;
          if (!is_write_q) rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
`ifdef PMEM_PROTOCOL_CHECK_EN
      addr_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
`ifdef PMEM_PROTOCOL_CHECK_EN
      addr_q     <= addr_d;
`endif
    end
  end

  // Array has no reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_idx] <= mem_wdata;
  end

  assign pmem_resp  = (state_q == RESP);
  assign pmem_rdata = rdata_q;
  assign error      = error_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: directed table, random traffic vs. line model,
// and hand sequences for protocol violations and mid-transaction reset.
module tb_pmem_line_responder;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         resp;
  logic [255:0] rdata;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] mem_m [256];
  int           known[$];
  logic [255:0] last_rd;

  pmem_line_responder dut (
    .clk(clk), .rst(rst), .pmem_read(rd), .pmem_write(wr),
    .pmem_address(addr), .pmem_wdata(wdata),
    .pmem_resp(resp), .pmem_rdata(rdata), .error(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_write;
    logic [31:0]  a;
    logic [255:0] d;
    logic [255:0] exp_rd;
  } vec_t;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    last_rd = '0;
  endtask

  task automatic wait_resp(input int budget, output int n, output bit got);
    n = 0; got = 1'b0;
    while (n < budget && !got) begin
      tick(); n++;
      if (resp) got = 1'b1;
    end
  endtask

  function automatic void model_apply(bit w, logic [31:0] a, logic [255:0] d);
    int idx = int'(a[12:5]);
    if (w) begin
      mem_m[idx] = d;
      known.push_back(idx);
    end else begin
      last_rd = mem_m[idx];
    end
  endfunction

  task automatic run_op(input bit w, input logic [31:0] a, input logic [255:0] d,
                        input logic [255:0] exp, input string nm);
    int n; bit got;
    rd = !w; wr = w; addr = a; wdata = d;
    wait_resp(40, n, got);
    chk({nm, " latency"}, 256'(got ? n : -1), 256'(LAT));
    chk({nm, " rdata"}, rdata, exp);
    rd = 1'b0; wr = 1'b0;
    tick();
    chk({nm, " pulse"}, 256'(resp), 256'(0));
    tick();
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    vec_t vecs[8];
    logic [255:0] l0, l1, la, lb;
    int n; bit got;

    l0 = 256'h0123_4567_89AB_CDEF;
    l1 = 256'h1111_2222_3333;
    la = 256'hA;
    lb = 256'hB;

    vecs[0] = '{1'b1, 32'h0000_0040, {8{32'hDEADBEEF}}, 256'h0};
    vecs[1] = '{1'b0, 32'h0000_0040, 256'h0, {8{32'hDEADBEEF}}};
    vecs[2] = '{1'b1, 32'h0000_0060, 256'h1, {8{32'hDEADBEEF}}};
    vecs[3] = '{1'b0, 32'h0000_007F, 256'h0, 256'h1};
    vecs[4] = '{1'b1, 32'h0000_0020, l1, 256'h1};
    vecs[5] = '{1'b1, 32'h0000_0000, l0, 256'h1};
    vecs[6] = '{1'b0, 32'h0000_0020, 256'h0, l1};
    vecs[7] = '{1'b0, 32'h0000_001F, 256'h0, l0};

    do_rst();
    chk("reset resp", 256'(resp), 256'(0));
    chk("reset rdata", rdata, 256'h0);
    chk("reset error", 256'(err), 256'(0));

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].is_write, vecs[i].a, vecs[i].d, vecs[i].exp_rd, $sformatf("vec%0d", i));
      model_apply(vecs[i].is_write, vecs[i].a, vecs[i].d);
    end

    for (int i = 0; i < 60; i++) begin
      bit w;
      int idx;
      logic [31:0] a;
      logic [255:0] d;
      w = ($urandom_range(1) == 1) || (known.size() == 0);
      idx = w ? int'($urandom_range(15)) : known[$urandom_range(known.size() - 1)];
      a = {19'h0, 8'(idx), 5'($urandom_range(31))};
`ifndef PMEM_PROTOCOL_CHECK_EN
      a[31:13] = 19'($urandom);
`endif
      d = rand_line();
      if (!w) last_rd = mem_m[idx];
      run_op(w, a, d, last_rd, $sformatf("rand%0d", i));
      model_apply(w, a, d);
    end

    // Write aborted by reset must not reach the array.
    run_op(1'b1, 32'h0000_0040, la, last_rd, "t6 prefill");
    model_apply(1'b1, 32'h0000_0040, la);
    rd = 1'b0; wr = 1'b1; addr = 32'h0000_0040; wdata = lb;
    wait_resp(5, n, got);
    chk("t6 no early resp", 256'(got), 256'(0));
    rst = 1'b1; wr = 1'b0;
    tick();
    rst = 1'b0; last_rd = '0;
    chk("t6 rdata after rst", rdata, 256'h0);
    wait_resp(20, n, got);
    chk("t6 no resp after rst", 256'(got), 256'(0));
    run_op(1'b0, 32'h0000_0040, 256'h0, la, "t6 readback");
    model_apply(1'b0, 32'h0000_0040, 256'h0);

    // Address changes mid-wait.
    run_op(1'b1, 32'h0000_0020, l1, last_rd, "t4 prefill");
    model_apply(1'b1, 32'h0000_0020, l1);
    rd = 1'b1; wr = 1'b0; addr = 32'h0000_0020;
    wait_resp(4, n, got);
    chk("t4 no early resp", 256'(got), 256'(0));
    addr = 32'h0000_0040;
`ifdef PMEM_PROTOCOL_CHECK_EN
    wait_resp(40, n, got);
    chk("t4 no resp", 256'(got), 256'(0));
    chk("t4 error", 256'(err), 256'(1));
    do_rst();
    chk("t4 error cleared", 256'(err), 256'(0));
`else
    wait_resp(30, n, got);
    chk("t4 latency", 256'(got ? n + 4 : -1), 256'(LAT));
    chk("t4 rdata", rdata, l1);
    chk("t4 error", 256'(err), 256'(0));
    last_rd = l1;
    rd = 1'b0;
    tick(); tick();
`endif

    // Out-of-range address.
    run_op(1'b1, 32'h0000_0000, l0, last_rd, "t5 prefill");
    model_apply(1'b1, 32'h0000_0000, l0);
`ifdef PMEM_PROTOCOL_CHECK_EN
    rd = 1'b1; wr = 1'b0; addr = 32'h0001_0000;
    wait_resp(40, n, got);
    chk("t5 no resp", 256'(got), 256'(0));
    chk("t5 error", 256'(err), 256'(1));
    do_rst();
`else
    run_op(1'b0, 32'h0001_0000, 256'h0, l0, "t5 alias");
    chk("t5 error", 256'(err), 256'(0));
`endif

    // Both request lines high.
    rd = 1'b1; wr = 1'b1; addr = 32'h0000_0000;
    tick();
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("t3 error next cycle", 256'(err), 256'(1));
`else
    chk("t3 error", 256'(err), 256'(0));
`endif
    wait_resp(50, n, got);
    chk("t3 no resp", 256'(got), 256'(0));
    rd = 1'b0; wr = 1'b0;
    tick(); tick();
`ifdef PMEM_PROTOCOL_CHECK_EN
    chk("t3 error sticky", 256'(err), 256'(1));
    do_rst();
    chk("t3 error cleared", 256'(err), 256'(0));
`else
    chk("t3 error idle", 256'(err), 256'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
